// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (LS):
// one transaction at a time, LS priority with a fetch anti-starvation streak, and a response timeout.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_done,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_be,
  output logic            ls_done,
  output logic [DW-1:0]   ls_rdata,
  output logic            err,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);
  localparam int BW = DW / 8;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
  typedef enum logic {OWN_IF, OWN_LS} owner_e;

  state_e          state_q;
  owner_e          own_q;
  logic [SW-1:0]   streak_q, streak_d;
  logic [TW-1:0]   timer_q;
  logic            mem_req_q, mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [BW-1:0]   mem_be_q;
  logic            if_done_q, ls_done_q, err_q;
  logic [DW-1:0]   if_rdata_q, ls_rdata_q;
  logic            grant, ls_wins, timed_out;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    ls_wins   = ls_req && !(if_req && streak_q == SW'(MAX_STREAK));
    grant     = (state_q == S_IDLE) && (if_req || ls_req);
    timed_out = timer_q >= TW'(TIMEOUT - 1);
    streak_d  = streak_q;
    if (!if_req) begin
      streak_d = '0;
    end else if (grant && !ls_wins) begin
      streak_d = '0;
    end else if (grant && streak_q != SW'(MAX_STREAK)) begin
      streak_d = streak_q + SW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the read-data holding registers are reset too, because every output must read 0 in reset.
      state_q     <= S_IDLE;
      own_q       <= OWN_IF;
      streak_q    <= '0;
      timer_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      streak_q  <= streak_d;
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant) begin
            own_q       <= ls_wins ? OWN_LS : OWN_IF;
            mem_we_q    <= ls_wins && ls_we;
            mem_addr_q  <= ls_wins ? ls_addr : if_addr;
            mem_wdata_q <= (ls_wins && ls_we) ? ls_wdata : '0;
            mem_be_q    <= (ls_wins && ls_we) ? ls_be : '1;
            mem_req_q   <= 1'b1;
            timer_q     <= '0;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= timer_q + TW'(1);
          if (mem_ready) begin
            mem_req_q <= 1'b0;
            if (mem_we_q) begin
              ls_done_q <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              state_q   <= S_WAIT;
            end
          end else if (timed_out) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            if_done_q <= (own_q == OWN_IF);
            ls_done_q <= (own_q == OWN_LS);
            if (own_q == OWN_IF) if_rdata_q <= '0;
            else                 ls_rdata_q <= '0;
            state_q   <= S_DONE;
          end
        end
        S_WAIT: begin
          timer_q <= timer_q + TW'(1);
          if (mem_rvalid || timed_out) begin
            // A late response loses to nothing; a timeout returns zero data with err.
            err_q     <= !mem_rvalid;
            if_done_q <= (own_q == OWN_IF);
            ls_done_q <= (own_q == OWN_LS);
            if (own_q == OWN_IF) if_rdata_q <= mem_rvalid ? mem_rdata : '0;
            else                 ls_rdata_q <= mem_rvalid ? mem_rdata : '0;
            state_q   <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_done   = if_done_q;
  assign ls_done   = ls_done_q;
  assign err       = err_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign stall_if  = if_req && !if_done_q;
  assign stall_mem = ls_req && !ls_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a reactive memory responder, a transaction-level
// model checked every cycle, and hand-computed latencies/data for each scenario.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, BW = 4, MAX_STREAK = 4, TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          ls_req = 1'b0, ls_we = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic [BW-1:0] ls_be = '0;
  logic          ls_done;
  logic [DW-1:0] ls_rdata;
  logic          err, stall_if, stall_mem;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_done(ls_done), .ls_rdata(ls_rdata), .err(err),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder configuration, set by the stimulus per scenario.
  int            cfg_ready_dly = 0;
  int            cfg_rv_gap = 1;
  bit            cfg_never = 1'b0;
  logic [DW-1:0] cfg_rdata = '0;
  bit            stray_rv = 1'b0;

  int req_cnt = 0;
  int rv_cnt = 0;
  always @(negedge clk) begin
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h1234_5678;
    if (!rst_n) begin
      req_cnt = 0;
      rv_cnt  = 0;
    end else begin
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0 && !cfg_never) begin
          mem_rvalid = 1'b1;
          mem_rdata  = cfg_rdata;
        end
      end
      if (stray_rv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
      end
      if (mem_req) begin
        if (req_cnt == cfg_ready_dly) begin
          mem_ready = 1'b1;
          if (!mem_we) rv_cnt = cfg_rv_gap;
        end
        req_cnt++;
      end else begin
        req_cnt = 0;
      end
    end
  end

  // Transaction-level model: predicts owner, request window and completion cycle from the
  // arbitration rule and the responder delays, then checks all outputs every cycle.
  int            cyc = 0;
  bit            m_busy = 1'b0, m_ls = 1'b0, m_we = 1'b0, m_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  logic [BW-1:0] m_be = '0;
  int            m_grant = 0, m_req_end = 0, m_done = 0, m_streak = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy   = 1'b0;
      m_streak = 0;
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_if_done", if_done, 0);
      check("rst_ls_done", ls_done, 0);
      check("rst_err", err, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_ls_rdata", ls_rdata, 0);
    end else begin
      bit exp_req, is_done;
      exp_req = m_busy && (cyc >= m_grant + 1) && (cyc <= m_req_end);
      is_done = m_busy && (cyc == m_done);
      check("mem_req", mem_req, exp_req);
      if (exp_req) begin
        check("mem_we", mem_we, m_we);
        check("mem_addr", mem_addr, m_addr);
        check("mem_be", mem_be, m_be);
        if (m_we) check("mem_wdata", mem_wdata, m_wdata);
      end
      check("if_done", if_done, is_done && !m_ls);
      check("ls_done", ls_done, is_done && m_ls);
      check("err", err, is_done && m_err);
      if (is_done && !m_ls) check("if_rdata", if_rdata, m_err ? '0 : m_rdata);
      if (is_done && m_ls && !m_we) check("ls_rdata", ls_rdata, m_err ? '0 : m_rdata);
      check("stall_if", stall_if, if_req && !(is_done && !m_ls));
      check("stall_mem", stall_mem, ls_req && !(is_done && m_ls));

      if (is_done) begin
        m_busy = 1'b0;
      end else if (!m_busy && (if_req || ls_req)) begin
        m_busy   = 1'b1;
        m_ls     = ls_req && !(if_req && m_streak >= MAX_STREAK);
        m_streak = (m_ls && if_req) ? m_streak + 1 : 0;
        m_we     = m_ls && ls_we;
        m_addr   = m_ls ? ls_addr : if_addr;
        m_wdata  = ls_wdata;
        m_be     = m_we ? ls_be : 4'hF;
        m_rdata  = cfg_rdata;
        m_grant  = cyc;
        m_req_end = cyc + 1 + cfg_ready_dly;
        m_err    = 1'b0;
        if (m_we)           m_done = cyc + 2 + cfg_ready_dly;
        else if (cfg_never) begin m_done = cyc + 1 + TIMEOUT; m_err = 1'b1; end
        else                m_done = cyc + 2 + cfg_ready_dly + cfg_rv_gap;
      end
      if (!if_req) m_streak = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, output int lat, output bit got_ls, output bit got_err);
    lat = 0; got_ls = 1'b0; got_err = 1'b0;
    while (lat < 200) begin
      tick();
      lat++;
      if (if_done || ls_done) begin
        got_ls  = ls_done;
        got_err = err;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: no done pulse within 200 cycles", name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit got_ls, got_err;
    logic [4:0] order;

    #2 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: single fetch, zero-wait memory
    cfg_ready_dly = 0; cfg_rv_gap = 1; cfg_never = 1'b0; cfg_rdata = 32'h0050_0093;
    if_addr = 32'h100; if_req = 1'b1;
    #1 check("t1_stall_if_on", stall_if, 1);
    wait_done("t1", lat, got_ls, got_err);
    check("t1_latency", lat, 3);
    check("t1_owner_ls", got_ls, 0);
    check("t1_if_rdata", if_rdata, 32'h0050_0093);
    check("t1_stall_if_done", stall_if, 0);
    if_req = 1'b0;
    tick();
    check("t1_pulse_one_cycle", if_done, 0);

    // 2: store, no WAIT phase
    ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'hF; ls_req = 1'b1;
    tick();
    check("t2_mem_req", mem_req, 1);
    check("t2_mem_we", mem_we, 1);
    check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("t2_ls_done", ls_done, 1);
    check("t2_err", err, 0);
    ls_req = 1'b0; ls_we = 1'b0;
    tick();

    // 3a: simultaneous requests, LS first then IF
    cfg_rdata = 32'h1111_2222;
    if_addr = 32'h104; ls_addr = 32'h300; if_req = 1'b1; ls_req = 1'b1;
    wait_done("t3a_first", lat, got_ls, got_err);
    check("t3a_first_is_ls", got_ls, 1);
    check("t3a_first_latency", lat, 3);
    ls_req = 1'b0;
    wait_done("t3a_second", lat, got_ls, got_err);
    check("t3a_second_is_if", got_ls, 0);
    check("t3a_second_latency", lat, 4);
    if_req = 1'b0;
    tick();

    // 3b: both held continuously, IF wins after MAX_STREAK LS grants
    if_req = 1'b1; ls_req = 1'b1;
    order = '0;
    for (int i = 0; i < 5; i++) begin
      wait_done("t3b", lat, got_ls, got_err);
      order = {order[3:0], got_ls};
    end
    check("t3b_grant_order", order, 5'b11110);
    if_req = 1'b0; ls_req = 1'b0;
    tick();

    // 4: slow memory, ready 3 cycles late, rvalid 2 cycles after ready
    cfg_ready_dly = 3; cfg_rv_gap = 2; cfg_rdata = 32'hCAFE_F00D;
    ls_addr = 32'h400; ls_req = 1'b1;
    wait_done("t4", lat, got_ls, got_err);
    check("t4_latency", lat, 7);
    check("t4_ls_rdata", ls_rdata, 32'hCAFE_F00D);
    ls_req = 1'b0;
    tick();

    // 5: rvalid never arrives -> timeout with err
    cfg_ready_dly = 0; cfg_rv_gap = 1; cfg_never = 1'b1;
    ls_addr = 32'h500; ls_req = 1'b1;
    wait_done("t5", lat, got_ls, got_err);
    check("t5_latency", lat, 65);
    check("t5_err", got_err, 1);
    check("t5_ls_rdata_zero", ls_rdata, 0);
    check("t5_mem_req_low", mem_req, 0);
    ls_req = 1'b0;
    tick();

    // 6: reset in WAIT, stray rvalid afterwards, then a normal load
    ls_addr = 32'h600; ls_req = 1'b1;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_mem_addr", mem_addr, 0);
    check("t6_async_mem_be", mem_be, 0);
    check("t6_async_if_rdata", if_rdata, 0);
    check("t6_async_ls_done", ls_done, 0);
    ls_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    stray_rv = 1'b1;
    tick();
    stray_rv = 1'b0;
    tick();
    check("t6_stray_no_done", ls_done, 0);
    check("t6_stray_no_data", ls_rdata, 0);
    cfg_never = 1'b0; cfg_rdata = 32'h600D_F00D;
    ls_addr = 32'h604; ls_req = 1'b1;
    wait_done("t6_after", lat, got_ls, got_err);
    check("t6_after_latency", lat, 3);
    check("t6_after_rdata", ls_rdata, 32'h600D_F00D);
    check("t6_after_err", got_err, 0);
    ls_req = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
